// File: rtl/ibus_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// ibus_sram_responder_pkg
//   Shared types for the instruction-bus SRAM responder:
//     ibus_req_t       - fetch request (valid, 64-bit byte address)
//     ibus_resp_t      - response (addr_ok, data_ok, 32-bit instruction word)
//     ibus_rsp_state_t - responder FSM states IDLE/WAIT/RESP
//     IBUS_LFSR_SEED   - reset value of the random-latency LFSR
//     ibus_lfsr_next   - one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
// ----------------------------------------------------------------------------
package ibus_sram_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ibus_rsp_state_t;

  localparam logic [7:0] IBUS_LFSR_SEED = 8'hA5;

  // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3) enters at bit 0.
  function automatic logic [7:0] ibus_lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/ibus_sram_responder_if.sv
// ----------------------------------------------------------------------------
// ibus_sram_responder_if
//   Instruction-bus bundle between a fetch stage and its responder.
//     req  : ibus_req_t,  driven by the initiator (master)
//     resp : ibus_resp_t, driven by the responder (slave)
// ----------------------------------------------------------------------------
interface ibus_sram_responder_if;
  import ibus_sram_responder_pkg::*;

  ibus_req_t  req;
  ibus_resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);

endinterface

// File: rtl/lat_lfsr.sv
// ----------------------------------------------------------------------------
// lat_lfsr
//   8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise responder latency.
//   Only built when IBUS_RAND_LAT_EN is defined.
//   Ports:
//     clk_i   - clock
//     rst_ni  - asynchronous active-low reset, loads IBUS_LFSR_SEED
//     adv_i   - advance strobe, one step per cycle while high
//     lfsr_o  - current LFSR value
// ----------------------------------------------------------------------------
`ifdef IBUS_RAND_LAT_EN
module lat_lfsr
  import ibus_sram_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       adv_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = ibus_lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= IBUS_LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/ibus_sram_responder.sv
// ----------------------------------------------------------------------------
// ibus_sram_responder
//   Responder end of the instruction bus, backed by a word-addressed SRAM
//   array with a configurable access latency. One request in flight; data_ok
//   follows addr_ok by exactly LATENCY cycles.
//   Parameters:
//     MEM_AW   - log2 of the array depth in 32-bit words
//     LATENCY  - addr_ok-to-data_ok cycles, 1..15
//     BAD_WORD - word returned for misaligned addresses
//   Ports:
//     clk      - clock, rising edge
//     reset    - asynchronous active-low reset (array contents are kept)
//     ibus     - slave side of ibus_sram_responder_if (req in, resp out)
//     wr_en    - backdoor program-load write strobe
//     wr_addr  - backdoor word index
//     wr_data  - backdoor write data
//   Build option:
//     IBUS_RAND_LAT_EN - adds lat_lfsr; latency becomes LATENCY + lfsr[1:0]
//                        sampled at acceptance.
// ----------------------------------------------------------------------------
module ibus_sram_responder
  import ibus_sram_responder_pkg::*;
#(
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] BAD_WORD = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  ibus_sram_responder_if.slave  ibus,
  input  logic                  wr_en,
  input  logic [MEM_AW-1:0]     wr_addr,
  input  logic [31:0]           wr_data
);

  ibus_rsp_state_t state_q, state_d;
  logic [63:0]     addr_q,  addr_d;
  logic [4:0]      cnt_q,   cnt_d;
  logic [31:0]     data_q,  data_d;

  logic [31:0]     mem_q [2**MEM_AW];

  logic            accept;
  logic            load_data;
  logic [4:0]      lat_eff;
  logic [63:0]     ld_addr;
  logic [MEM_AW-1:0] rd_idx;
  logic [31:0]     rd_word;
  logic            unused_addr_hi;

`ifdef IBUS_RAND_LAT_EN
  logic [7:0] lfsr;
  logic       unused_lfsr_hi;

  lat_lfsr u_lat_lfsr (
    .clk_i  (clk),
    .rst_ni (reset),
    .adv_i  (accept),
    .lfsr_o (lfsr)
  );

  assign lat_eff        = 5'(LATENCY) + {3'b000, lfsr[1:0]};
  assign unused_lfsr_hi = ^lfsr[7:2];
`else
  assign lat_eff = 5'(LATENCY);
`endif

  // With a latency of 1 the data register is loaded on the accepting edge,
  // before addr_q holds the address, so read through the live request.
  assign ld_addr        = (state_q == IDLE) ? ibus.req.addr : addr_q;
  assign rd_idx         = ld_addr[MEM_AW+1:2];
  assign rd_word        = (wr_en && (wr_addr == rd_idx)) ? wr_data : mem_q[rd_idx];
  assign unused_addr_hi = ^ld_addr[63:MEM_AW+2];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    accept    = 1'b0;
    load_data = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ibus.req.valid) begin
          accept = 1'b1;
          addr_d = ibus.req.addr;
          cnt_d  = lat_eff - 5'd1;
          if (lat_eff == 5'd1) begin
            state_d   = RESP;
            load_data = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d   = RESP;
          load_data = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_data) data_d = (ld_addr[1:0] != 2'b00) ? BAD_WORD : rd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // addr_ok is combinational from valid, so it is also held low while in reset.
  assign ibus.resp = '{addr_ok: (state_q == IDLE) && ibus.req.valid && reset,
                       data_ok: (state_q == RESP),
                       data:    data_q};

  // The initiator must hold its request stable until the response arrives.
  a_wait_valid_held: assert property (@(posedge clk) disable iff (!reset)
    (state_q == WAIT) |-> ibus.req.valid);
  a_wait_addr_held: assert property (@(posedge clk) disable iff (!reset)
    (state_q == WAIT) |-> (ibus.req.addr == addr_q));

endmodule

// File: tb/tb_ibus_sram_responder.sv
module tb_ibus_sram_responder;
  import ibus_sram_responder_pkg::*;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;
  localparam logic [31:0] BAD = 32'h0BAD_F00D;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;

  ibus_sram_responder_if bus ();

  ibus_sram_responder #(
    .MEM_AW   (AW),
    .LATENCY  (LAT),
    .BAD_WORD (BAD)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .ibus    (bus.slave),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // One outstanding request; it is answered lat cycles after acceptance and
  // the responder is free again the cycle after the answer.
  logic [31:0] shadow [2**AW];
  bit          pend     = 1'b0;
  int          cyc      = 0;
  int          resp_cyc = 0;
  logic [63:0] m_addr   = '0;
  logic [31:0] m_data   = '0;
  logic [31:0] nxt_data = '0;
`ifdef IBUS_RAND_LAT_EN
  logic [7:0]  m_lfsr   = 8'hA5;
`endif

  always @(negedge clk) begin
    bit acc;
    int lat;
    int idx;
    if (!rst_n) begin
      chk("rst_addr_ok", 64'(bus.resp.addr_ok), 64'd0);
      chk("rst_data_ok", 64'(bus.resp.data_ok), 64'd0);
      chk("rst_data",    64'(bus.resp.data),    64'd0);
      pend   = 1'b0;
      m_data = '0;
`ifdef IBUS_RAND_LAT_EN
      m_lfsr = 8'hA5;
`endif
    end else begin
      acc = bus.req.valid && !pend;
      chk("addr_ok", 64'(bus.resp.addr_ok), 64'(acc));
      chk("data_ok", 64'(bus.resp.data_ok), 64'(pend && cyc == resp_cyc));
      if (pend && cyc == resp_cyc) begin
        m_data = nxt_data;
        pend   = 1'b0;
      end
      chk("data", 64'(bus.resp.data), 64'(m_data));
      if (acc) begin
        lat = LAT;
`ifdef IBUS_RAND_LAT_EN
        lat    = lat + int'(m_lfsr[1:0]);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        pend     = 1'b1;
        m_addr   = bus.req.addr;
        resp_cyc = cyc + lat;
      end
      // The word is captured by the edge that ends the cycle before the answer.
      if (pend && cyc == resp_cyc - 1) begin
        idx = int'(m_addr % 64'(4 * (2**AW))) / 4;
        if (m_addr[1:0] != 2'b00)                  nxt_data = BAD;
        else if (wr_en && int'(wr_addr) == idx)    nxt_data = wr_data;
        else                                       nxt_data = shadow[idx];
      end
    end
    if (wr_en) shadow[wr_addr] = wr_data;
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(idx);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Presents a request (starting in an idle cycle) and waits for its answer.
  task automatic fetch(input logic [63:0] a, input logic [31:0] exp, input int lat,
                       output int got_lat);
    int  t0;
    bit  done;
    t0      = -1;
    done    = 1'b0;
    got_lat = -1;
    bus.req.valid = 1'b1;
    bus.req.addr  = a;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (t0 < 0 && bus.resp.addr_ok) t0 = n;
      if (bus.resp.data_ok) begin
        done    = 1'b1;
        got_lat = n - t0;
        chk("fetch_data", 64'(bus.resp.data), 64'(exp));
`ifndef IBUS_RAND_LAT_EN
        chk("fetch_latency", 64'(got_lat), 64'(lat));
`endif
      end
    end
    chk("fetch_done", 64'(done), 64'd1);
    chk("fetch_accept_cycle", 64'(t0), 64'd0);
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
`ifdef IBUS_RAND_LAT_EN
    int seq [2][16];
`endif
    bus.req.valid = 1'b0;
    bus.req.addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single fetch of word 0, then the same request again in cycle 3
    load(0, 32'h0000_0013);
    fetch(64'h0, 32'h0000_0013, 2, l);
    fetch(64'h0, 32'h0000_0013, 2, l);
    bus.req.valid = 1'b0;

    // 2: fetch stream 0,4,8 back to back
    load(0, 32'd1);
    load(1, 32'd2);
    load(2, 32'd3);
    fetch(64'h0, 32'd1, 2, l);
    fetch(64'h4, 32'd2, 2, l);
    fetch(64'h8, 32'd3, 2, l);

    // 3: misaligned and aliased addresses
    fetch(64'h2, BAD, 2, l);
    fetch(64'h4000, 32'd1, 2, l);
    fetch(64'hFFFF_0000_0000_4008, 32'd3, 2, l);
    bus.req.valid = 1'b0;
    step();

`ifndef IBUS_RAND_LAT_EN
    // 4: backdoor write on the edge entering RESP is bypassed, a later one is not
    load(5, 32'h5555_5555);
    bus.req.valid = 1'b1;
    bus.req.addr  = 64'h14;
    step();
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF;
    step();
    bus.req.valid = 1'b0;
    wr_data = 32'h7777_7777;
    @(negedge clk);
    chk("bypass_data_ok", 64'(bus.resp.data_ok), 64'd1);
    chk("bypass_data", 64'(bus.resp.data), 64'hDEAD_BEEF);
    step();
    wr_en = 1'b0;
    // write on the accepting edge is visible
    load(6, 32'h1111_1111);
    bus.req.valid = 1'b1;
    bus.req.addr  = 64'h18;
    wr_en = 1'b1; wr_addr = AW'(6); wr_data = 32'h6666_6666;
    step();
    wr_en = 1'b0;
    step();
    bus.req.valid = 1'b0;
    @(negedge clk);
    chk("early_wr_data_ok", 64'(bus.resp.data_ok), 64'd1);
    chk("early_wr_data", 64'(bus.resp.data), 64'h6666_6666);
    step();
    fetch(64'h14, 32'h7777_7777, 2, l);
    bus.req.valid = 1'b0;
    step();
`endif

    // 5: reset during WAIT abandons the request
    bus.req.valid = 1'b1;
    bus.req.addr  = 64'h8;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_iresp", 64'({bus.resp.addr_ok, bus.resp.data_ok, bus.resp.data}), 64'd0);
    step();
    step();
    bus.req.valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();
    fetch(64'h0, 32'd1, 2, l);
    bus.req.valid = 1'b0;
    step();

`ifdef IBUS_RAND_LAT_EN
    // 6: random latency stays in range and repeats from reset
    for (int r = 0; r < 2; r++) begin
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
        fetch(64'h0, 32'd1, -1, l);
        seq[r][i] = l;
        chk("rand_lat_range", 64'(l >= 2 && l <= 5), 64'd1);
      end
      bus.req.valid = 1'b0;
      step();
    end
    for (int i = 0; i < 16; i++) chk("rand_lat_repeat", 64'(seq[1][i]), 64'(seq[0][i]));
    chk("rand_lat_first", 64'(seq[0][0]), 64'd3);
    chk("rand_lat_second", 64'(seq[0][1]), 64'd4);
`else
    pulse_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
